// File: rtl/dpwm_pkg.sv
// Shared types, default widths and phase-offset arithmetic for the interleaved DPWM.
package dpwm_pkg;

  localparam int unsigned DefaultNphases = 4;
  localparam int unsigned DefaultCntW    = 7;
  localparam int unsigned DefaultDtW     = 3;

  typedef enum logic [1:0] {StOff, StDead, StHigh, StLow} dt_state_e;

  // nphases is a power of two, so the divide reduces to a shift.
  function automatic int unsigned phase_offset(int unsigned k, int unsigned p,
                                               int unsigned nphases);
    return (k * p) >> $clog2(nphases);
  endfunction

endpackage

// File: rtl/dpwm_deadtime.sv
// Per-phase dead-time inserter: turns a raw PWM level into non-overlapping high/low gates.
module dpwm_deadtime
  import dpwm_pkg::*;
#(
  parameter int unsigned DT_W = DefaultDtW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic            en_phase,
  input  logic [DT_W-1:0] dead_time,
  output logic            hi,
  output logic            lo
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] dcnt_q, dcnt_d;
  logic            target_q, target_d;
  logic            restart;

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    target_d = target_q;
    restart  = 1'b0;
    if (!en_phase) begin
      state_d  = StOff;
      dcnt_d   = '0;
      target_d = 1'b0;
    end else begin
      unique case (state_q)
        StOff:  restart = 1'b1;
        StHigh: restart = ~raw;
        StLow:  restart = raw;
        StDead: begin
          if (raw != target_q) begin
            restart = 1'b1;
          end else if (dcnt_q <= DT_W'(1)) begin
            state_d = target_q ? StHigh : StLow;
          end else begin
            dcnt_d = dcnt_q - DT_W'(1);
          end
        end
        default: state_d = StOff;
      endcase
      // Any level change (or leaving Off) drops both gates before the new side turns on.
      if (restart) begin
        target_d = raw;
        if (dead_time == '0) begin
          state_d = raw ? StHigh : StLow;
          dcnt_d  = '0;
        end else begin
          state_d = StDead;
          dcnt_d  = dead_time;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StOff;
      dcnt_q   <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      target_q <= target_d;
    end
  end

  assign hi = (state_q == StHigh);
  assign lo = (state_q == StLow);

endmodule

// File: rtl/multiphase_dpwm.sv
// N-phase interleaved DPWM: one master counter, per-phase offsets, dead-time gate drivers.
module multiphase_dpwm
  import dpwm_pkg::*;
#(
  parameter int unsigned NPHASES = DefaultNphases,
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned DT_W    = DefaultDtW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   duty,
  input  logic [DT_W-1:0]    dead_time,
  input  logic [NPHASES-1:0] phase_en,
  output logic [NPHASES-1:0] pwm_high,
  output logic [NPHASES-1:0] pwm_low,
  output logic               cycle_start
);

  localparam logic [CNT_W-1:0] PMin = CNT_W'(NPHASES);

  logic               run_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_sh, duty_sh, p_eff;
  logic [DT_W-1:0]    dt_sh;
  logic [NPHASES-1:0] pen_sh;
  logic               wrap, load;

  assign p_eff = (period_sh < PMin) ? PMin : period_sh;
  assign wrap  = (cnt_q >= p_eff - CNT_W'(1));
  // Shadows refresh at each period boundary and on the first enabled edge.
  assign load  = en & (~run_q | wrap);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || !run_q || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
      dt_sh     <= '0;
      pen_sh    <= '0;
    end else begin
      run_q <= en;
      cnt_q <= cnt_d;
      if (load) begin
        period_sh <= period;
        duty_sh   <= duty;
        dt_sh     <= dead_time;
        pen_sh    <= phase_en;
      end
    end
  end

  assign cycle_start = run_q & (cnt_q == '0);

  for (genvar k = 0; k < NPHASES; k++) begin : g_phase
    logic [CNT_W-1:0] off, pc;
    logic             raw;

    assign off = CNT_W'(phase_offset(k, 32'(p_eff), NPHASES));
    // Result is always below p_eff, so modular CNT_W arithmetic is exact.
    assign pc  = cnt_q - off + ((cnt_q >= off) ? '0 : p_eff);
    assign raw = (pc < duty_sh);

    dpwm_deadtime #(
      .DT_W(DT_W)
    ) u_deadtime (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw),
      .en_phase (run_q & en & pen_sh[k]),
      .dead_time(dt_sh),
      .hi       (pwm_high[k]),
      .lo       (pwm_low[k])
    );
  end

endmodule

// File: doc/multiphase_dpwm.md
# multiphase_dpwm

Parametrised N-phase interleaved digital PWM generator with per-phase complementary high/low gate outputs and programmable dead time. It replaces the single-counter DPWM plus shift-register phase shifter in the buck-converter datapath. Duty comes from the compensator or the manual SPI register; period, dead time and phase enables come from the SPI register file. All operating values are double-buffered so that they change only on a switching-period boundary.

## Interface
- `NPHASES`, default 4: number of phases; must be a power of two, 1..8.
- `CNT_W`, default 7: width of the period counter and of the duty value.
- `DT_W`, default 3: width of the dead-time value.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous and active-low (asserted at 0).
- `en  in  1`: run enable; low forces all gate outputs low.
- `period  in  CNT_W`: clk cycles per switching period. Values below `NPHASES` are treated as `NPHASES`.
- `duty  in  CNT_W`: high-side on-time in clk cycles.
- `dead_time  in  DT_W`: idle cycles inserted before the incoming side turns on.
- `phase_en  in  NPHASES`: per-phase enable.
- `pwm_high  out  NPHASES`: high-side gate per phase.
- `pwm_low  out  NPHASES`: low-side gate per phase.
- `cycle_start  out  1`: one-cycle pulse while the master counter is 0.

## Operation
- **Shadow registers.** `period`, `duty`, `dead_time` and `phase_en` are copied into shadows:
  - on the edge where `cnt` wraps to 0;
  - on the first edge with `en` high after `en` was low.
  - Mid-period input changes have no effect until the next load.
- **Master counter `cnt`.** Counts 0..P-1 and wraps, where P is the shadowed period after the clamp. It is held at 0 while `en` is low.
- **Phase offsets.** `off_k = (k*P) >> log2(NPHASES)`, computed from the shadowed P.
- **Phase counter.**
  - `pc_k = cnt - off_k` if `cnt >= off_k`,
  - otherwise `cnt + P - off_k`.
- **Raw PWM.** `raw_k = (pc_k < duty_sh)`.
  - `duty_sh = 0` gives raw always 0.
  - `duty_sh >= P` gives raw always 1, which is 100%.
- **Disabled phase** (`phase_en_sh[k] = 0`): both outputs are 0 and the dead-time state is cleared. Offsets of the other phases do not change.
- **Dead-time insertion**, per phase, with a registered state:
  - When `raw_k` differs from the last applied level, both outputs go 0 on the next edge and the counter loads `dead_time_sh`.
  - The new side is asserted once the counter reaches 0.
  - A raw change during the dead interval restarts the count toward the new level.
  - With `dead_time_sh = 0`: `pwm_high = raw`, `pwm_low = ~raw`, registered.
- **Invariant:** `pwm_high[k] & pwm_low[k]` is never 1.
- **`en` low:** all outputs 0 and `cycle_start` 0 from the next edge, counters cleared. Restarting with `en` high begins at `cnt = 0`.

## Timing
- Reset values: `cnt = 0`, shadows = 0, `pwm_high = 0`, `pwm_low = 0`, `cycle_start = 0`.
- Reset clears immediately (asynchronous), including mid-period.
- Old side deasserts 1 cycle after `raw_k` changes. New side asserts `1 + dead_time_sh` cycles after the change.
- High pulse width = `duty_sh - dead_time_sh`, floored at 0 cycles.
- `cycle_start` is aligned with `cnt == 0`, not delayed. Gate outputs lag `cnt` by one register stage.
- First period after `en` rises:
  - phase 0 `pwm_high` rises at cycle `1 + dead_time_sh`;
  - `pwm_low` is 0 until its first raw-low interval plus dead time.

## Structure
- Package `dpwm_pkg`: a function for the offset computation and constants for the default widths.
- Sub-module `dpwm_deadtime`, one instance per phase. Inputs: `raw`, `en_phase`, `dead_time`. Outputs: `hi`, `lo`.
- Top level contains the shadows, master counter, offset and phase-count arithmetic, and the generate loop.

## Test plan
- **Baseline.** `NPHASES=4`, period=100, duty=25, dt=0, all phases enabled. Expect `pwm_high[k]` high for 25 cycles starting 1 cycle after `cnt = 25k`; `pwm_low` is the exact complement; `cycle_start` every 100 cycles.
- **Dead time.** dt=3, duty=25. Expect the low side to fall 1 cycle after each raw rise and the high side to rise 4 cycles after it, giving a 22-cycle high width. Expect no cycle with both gates high, and 3 both-low cycles at each edge.
- **Shadow update.** Change duty 25→50 at `cnt = 40`. Expect current-period widths of 25 and next-period widths of 50 on all phases. Change period 100→80 mid-period: offsets become 0/20/40/60 from the next `cnt = 0`.
- **Extreme duty.** duty=0 gives `pwm_high` always 0 and `pwm_low` always 1. Duty=120 with period=100 gives `pwm_high` always 1 and `pwm_low` always 0. Period=2 with `NPHASES=4` is clamped to P=4.
- **Phase shedding.** `phase_en = 4'b0101`. Phases 1 and 3 have both gates 0 from the next period; phases 0 and 2 keep offsets 0 and 50.
- **Reset and disable.** Assert `rst` low at `cnt = 37` with dt=3 active: all outputs 0 immediately. Release `rst` with `en` high: restart from `cnt = 0`. Drop `en` mid-pulse: all outputs 0 on the next edge.
